// File: rtl/coax_pkg.sv
// Shared definitions for the coax transmitter: word geometry, state encoding and cell helpers.
package coax_pkg;

  localparam int WORD_WIDTH      = 10;
  localparam int START_BIT_COUNT = 5;

  typedef enum logic [3:0] {
    IDLE,
    START_BIT,
    VIOLATION_LOW,
    VIOLATION_HIGH,
    SYNC_BIT,
    DATA_BIT,
    PARITY_BIT,
    END_SYNC,
    END_HIGH
  } tx_state_t;

  // Manchester-style cell: complement in the first half, true value in the second.
  function automatic logic cell_level(input logic b, input logic first_half);
    return first_half ? ~b : b;
  endfunction

  // Even parity over the sync bit plus the word, optionally inverted.
  function automatic logic word_parity(input logic [WORD_WIDTH-1:0] w, input logic inv);
    return ~(^w) ^ inv;
  endfunction

endpackage

// File: rtl/coax_tx_bit_timer.sv
// Free-running cell timer: mid-cell and end-cell strobes every CLOCKS_PER_BIT clocks.
// Held at the start of a cell while restart is asserted.
module coax_tx_bit_timer #(
  parameter int CLOCKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic cell_mid,
  output logic cell_end,
  output logic first_half
);

  localparam int CNT_W = $clog2(CLOCKS_PER_BIT);

  logic [CNT_W-1:0] cnt;

  assign cell_end   = (cnt == CNT_W'(CLOCKS_PER_BIT - 1));
  assign cell_mid   = (cnt == CNT_W'(CLOCKS_PER_BIT / 2 - 1));
  assign first_half = (cnt <  CNT_W'(CLOCKS_PER_BIT / 2));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (restart || cell_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/coax_tx.sv
// Coax word transmitter: one-entry holding register feeding a framed, bi-phase encoded line.
// Optional COAX_TX_PARITY_INJECT_EN adds inject_parity_error to corrupt a word's parity cell.
module coax_tx
  import coax_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_WIDTH-1:0] data,
  input  logic                  load,
  output logic                  full,
  output logic                  active,
  output logic                  tx
`ifdef COAX_TX_PARITY_INJECT_EN
  ,
  input  logic                  inject_parity_error
`endif
);

  tx_state_t             state;
  logic [WORD_WIDTH-1:0] hold;
  logic [WORD_WIDTH-1:0] shift;
  logic                  hold_inj;
  logic                  parity;
  logic                  inj;
  logic [3:0]            bit_cnt;
  logic                  cell_mid;
  logic                  cell_end;
  logic                  first_half;
  logic                  tx_next;

`ifdef COAX_TX_PARITY_INJECT_EN
  assign inj = inject_parity_error;
`else
  assign inj = 1'b0;
`endif

  coax_tx_bit_timer #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .restart    (state == IDLE),
    .cell_mid   (cell_mid),
    .cell_end   (cell_end),
    .first_half (first_half)
  );

  always_comb begin
    tx_next = 1'b0;
    case (state)
      START_BIT, SYNC_BIT:      tx_next = cell_level(1'b1, first_half);
      VIOLATION_HIGH, END_HIGH: tx_next = 1'b1;
      DATA_BIT:                 tx_next = cell_level(shift[WORD_WIDTH-1], first_half);
      PARITY_BIT:               tx_next = cell_level(parity, first_half);
      END_SYNC:                 tx_next = cell_level(1'b0, first_half);
      default:                  tx_next = 1'b0;
    endcase
  end

  // Line outputs lag the state by one clock so tx and active stay aligned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tx       <= 1'b0;
      active   <= 1'b0;
      full     <= 1'b0;
      hold     <= '0;
      hold_inj <= 1'b0;
      shift    <= '0;
      parity   <= 1'b0;
      bit_cnt  <= '0;
    end else begin
      tx     <= tx_next;
      active <= (state != IDLE);

      // Capture and transfer never coincide: one needs full=0, the other full=1.
      if (load && !full) begin
        hold     <= data;
        hold_inj <= inj;
        full     <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (full) begin
            shift   <= hold;
            parity  <= word_parity(hold, hold_inj);
            full    <= 1'b0;
            bit_cnt <= '0;
            state   <= START_BIT;
          end
        end
        START_BIT: begin
          if (cell_end) begin
            if (bit_cnt == 4'(START_BIT_COUNT - 1)) begin
              bit_cnt <= '0;
              state   <= VIOLATION_LOW;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        // The 1.5-cell violation halves straddle a cell boundary; bit_cnt marks the first boundary seen.
        VIOLATION_LOW: begin
          if (cell_end) begin
            bit_cnt <= 4'd1;
          end else if (cell_mid && bit_cnt == 4'd1) begin
            bit_cnt <= '0;
            state   <= VIOLATION_HIGH;
          end
        end
        VIOLATION_HIGH: begin
          if (cell_end) begin
            if (bit_cnt == 4'd1) begin
              bit_cnt <= '0;
              state   <= SYNC_BIT;
            end else begin
              bit_cnt <= 4'd1;
            end
          end
        end
        SYNC_BIT: begin
          if (cell_end) state <= DATA_BIT;
        end
        DATA_BIT: begin
          if (cell_end) begin
            shift <= {shift[WORD_WIDTH-2:0], 1'b0};
            if (bit_cnt == 4'(WORD_WIDTH - 1)) begin
              bit_cnt <= '0;
              state   <= PARITY_BIT;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        PARITY_BIT: begin
          if (cell_end) begin
            if (full) begin
              shift  <= hold;
              parity <= word_parity(hold, hold_inj);
              full   <= 1'b0;
              state  <= SYNC_BIT;
            end else begin
              state  <= END_SYNC;
            end
          end
        end
        END_SYNC: begin
          if (cell_end) state <= END_HIGH;
        end
        END_HIGH: begin
          if (cell_end) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
